// File: rtl/pic_timer_pkg.sv
// Shared constants for the PIC16F54 Timer0/WDT clock block: OPTION bit positions,
// default watchdog period and prescaler width.
package pic_timer_pkg;

  localparam int T0CS_BIT = 5;
  localparam int T0SE_BIT = 4;
  localparam int PSA_BIT  = 3;
  localparam int PS_HI    = 2;
  localparam int PS_LO    = 0;

  localparam int WDT_PERIOD_DEF = 18000;
  localparam int PSC_W          = 8;

  // Mask with the lowest nbits bits set (nbits = 0..8)
  function automatic logic [PSC_W-1:0] low_mask(input logic [3:0] nbits);
    return PSC_W'((9'd1 << nbits) - 9'd1);
  endfunction

endpackage

// File: rtl/tmr0_wdt_prescaler_t0cki_sync.sv
// T0CKI pin synchroniser: two metastability flops, a history flop, and a registered
// one-cycle pulse on the edge selected by T0SE (0 = rising, 1 = falling).
module t0cki_sync (
  input  logic clk,
  input  logic rst,
  input  logic t0cki,
  input  logic t0se,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= t0cki;
      sync2      <= sync1;
      hist       <= sync2;
      edge_pulse <= t0se ? (hist & ~sync2) : (sync2 & ~hist);
    end
  end

endmodule

// File: rtl/tmr0_wdt_prescaler.sv
// Timer0 clock source, shared 8-bit prescaler and watchdog base counter.
// Watchdog logic is present only when PIC_WDT_EN is defined; otherwise wdtmr stays 0.
module tmr0_wdt_prescaler
  import pic_timer_pkg::*;
#(
  parameter int WDT_PERIOD = WDT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] option_out,
  input  logic       t0cki,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       tmr0_wr,
  output logic       tmr0_inc,
  output logic       wdtmr
);

  logic             t0cs;
  logic             t0se;
  logic             psa;
  logic [2:0]       ps;
  logic             ext_ev;
  logic             src_ev;
  logic             psa_q;
  logic             wdt_clr;
  logic             wdt_tick;
  logic             psc_clr;
  logic             tmr0_ev;
  logic             wdt_to;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_nxt;
  logic             unused_sink;

  assign t0cs = option_out[T0CS_BIT];
  assign t0se = option_out[T0SE_BIT];
  assign psa  = option_out[PSA_BIT];
  assign ps   = option_out[PS_HI:PS_LO];

  t0cki_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .t0cki      (t0cki),
    .t0se       (t0se),
    .edge_pulse (ext_ev)
  );

  assign src_ev = t0cs ? ext_ev : 1'b1;

`ifdef PIC_WDT_EN
  localparam int             WDT_W    = $clog2(WDT_PERIOD);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_PERIOD - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // A clear in the same cycle as the wrap wins, so no tick is produced
  assign wdt_clr  = clrwdt | sleep;
  assign wdt_tick = ~wdt_clr & (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (rst || wdt_clr || wdt_tick) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  assign unused_sink = ^option_out[7:6];
`else
  assign wdt_clr     = 1'b0;
  assign wdt_tick    = 1'b0;
  assign unused_sink = ^{option_out[7:6], clrwdt, sleep, WDT_PERIOD[0]};
`endif

  // Prescaler routing; any clear suppresses the increment and the event it would produce
  always_comb begin
    psc_nxt = psc;
    tmr0_ev = 1'b0;
    wdt_to  = 1'b0;
    psc_clr = (psa ^ psa_q) | (psa ? wdt_clr : tmr0_wr);
    if (!psa) begin
      wdt_to = wdt_tick;
      if (psc_clr) begin
        psc_nxt = '0;
      end else if (src_ev) begin
        psc_nxt = psc + 1'b1;
        tmr0_ev = ((psc_nxt & low_mask({1'b0, ps} + 4'd1)) == '0);
      end
    end else begin
      tmr0_ev = src_ev;
      if (psc_clr) begin
        psc_nxt = '0;
      end else if (wdt_tick) begin
        psc_nxt = psc + 1'b1;
        wdt_to  = ((psc_nxt & low_mask({1'b0, ps})) == '0);
      end
      if (ps == 3'd0) begin
        wdt_to = wdt_tick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc      <= '0;
      psa_q    <= 1'b0;
      tmr0_inc <= 1'b0;
      wdtmr    <= 1'b0;
    end else begin
      psc      <= psc_nxt;
      psa_q    <= psa;
      tmr0_inc <= tmr0_ev;
      wdtmr    <= wdt_to;
    end
  end

endmodule

// File: tb/tb_tmr0_wdt_prescaler.sv
// Self-checking bench for tmr0_wdt_prescaler: directed scenarios plus a randomized run
// compared every cycle against a cycle-level behavioural model.
module tb_tmr0_wdt_prescaler;

  localparam int P = 16;
`ifdef PIC_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] option_out = 8'h00;
  logic       t0cki = 1'b0;
  logic       clrwdt = 1'b0;
  logic       sleep = 1'b0;
  logic       tmr0_wr = 1'b0;
  logic       tmr0_inc;
  logic       wdtmr;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // reference model state
  int m_psc;
  int m_wdt;
  int m_ps;
  bit m_shadow;
  bit m_prev_t0se;
  bit m_pin[4];
  bit m_src, m_wclr, m_tick, m_pclr, m_ev, m_to;
  bit exp_inc = 1'b0;
  bit exp_wdt = 1'b0;

  always #5 clk = ~clk;

  tmr0_wdt_prescaler #(.WDT_PERIOD(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .option_out (option_out),
    .t0cki      (t0cki),
    .clrwdt     (clrwdt),
    .sleep      (sleep),
    .tmr0_wr    (tmr0_wr),
    .tmr0_inc   (tmr0_inc),
    .wdtmr      (wdtmr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Behavioural model: m_pin[i] holds the pin as sampled i+1 edges ago
  always @(posedge clk) begin
    if (rst) begin
      m_psc = 0;
      m_wdt = 0;
      m_shadow = 1'b0;
      m_prev_t0se = 1'b0;
      for (int i = 0; i < 4; i++) m_pin[i] = 1'b0;
      exp_inc = 1'b0;
      exp_wdt = 1'b0;
    end else begin
      m_ps = int'(option_out[2:0]);
      if (!option_out[5]) m_src = 1'b1;
      else if (!m_prev_t0se) m_src = m_pin[2] && !m_pin[3];
      else m_src = !m_pin[2] && m_pin[3];
      m_wclr = WDT_EN && (clrwdt || sleep);
      m_tick = 1'b0;
      if (WDT_EN) begin
        if (m_wclr) m_wdt = 0;
        else begin
          m_wdt = (m_wdt + 1) % P;
          m_tick = (m_wdt == 0);
        end
      end
      m_pclr = (option_out[3] != m_shadow) || (!option_out[3] && tmr0_wr) || (option_out[3] && m_wclr);
      m_ev = 1'b0;
      m_to = 1'b0;
      if (!option_out[3]) begin
        m_to = m_tick;
        if (m_pclr) m_psc = 0;
        else if (m_src) begin
          m_psc = (m_psc + 1) % 256;
          m_ev = (m_psc % (1 << (m_ps + 1))) == 0;
        end
      end else begin
        m_ev = m_src;
        if (m_pclr) m_psc = 0;
        else if (m_tick) begin
          m_psc = (m_psc + 1) % 256;
          m_to = (m_psc % (1 << m_ps)) == 0;
        end
        if (m_ps == 0) m_to = m_tick;
      end
      m_shadow = option_out[3];
      exp_inc = m_ev;
      exp_wdt = m_to;
      m_pin[3] = m_pin[2];
      m_pin[2] = m_pin[1];
      m_pin[1] = m_pin[0];
      m_pin[0] = t0cki;
      m_prev_t0se = option_out[4];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_tmr0_inc", tmr0_inc, exp_inc);
      checkOutput("model_wdtmr", wdtmr, exp_wdt);
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] opt, input bit wr, input bit cw, input bit sl);
    @(negedge clk);
    option_out = opt;
    tmr0_wr = wr;
    clrwdt = cw;
    sleep = sl;
  endtask

  task automatic countPulses(input int n, output int ni, output int nw);
    ni = 0;
    nw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tmr0_inc === 1'b1) ni++;
      if (wdtmr === 1'b1) nw++;
    end
  endtask

  task automatic waitPulse(input bit use_wdt, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((use_wdt ? wdtmr : tmr0_inc) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int ni, nw, n, hold;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyReset();
    checkOutput("reset_tmr0_inc", tmr0_inc, 0);
    checkOutput("reset_wdtmr", wdtmr, 0);

    countPulses(100, ni, nw);
    checkOutput("int_ps0_rate", ni, 50);
    applyStimulus(8'h07, 1'b0, 1'b0, 1'b0);
    countPulses(512, ni, nw);
    checkOutput("int_ps7_rate", ni, 2);

    applyStimulus(8'h28, 1'b0, 1'b0, 1'b0);
    t0cki = 1'b0;
    countPulses(8, ni, nw);
    ni = 0;
    for (int k = 0; k < 106; k++) begin
      t0cki = (k < 100) && ((k % 10) < 5);
      @(negedge clk);
      if (tmr0_inc === 1'b1) ni++;
    end
    checkOutput("ext_rising_count", ni, 10);
    t0cki = 1'b1;
    waitPulse(1'b0, 10, n);
    checkOutput("ext_rising_latency", n, 4);

    applyStimulus(8'h38, 1'b0, 1'b0, 1'b0);
    t0cki = 1'b0;
    countPulses(8, ni, nw);
    ni = 0;
    for (int k = 0; k < 106; k++) begin
      t0cki = (k < 100) && ((k % 10) < 5);
      @(negedge clk);
      if (tmr0_inc === 1'b1) ni++;
    end
    checkOutput("ext_falling_count", ni, 10);
    t0cki = 1'b1;
    countPulses(6, ni, nw);
    checkOutput("ext_falling_ignores_rise", ni, 0);
    t0cki = 1'b0;
    waitPulse(1'b0, 10, n);
    checkOutput("ext_falling_latency", n, 4);

`ifdef PIC_WDT_EN
    applyStimulus(8'h0A, 1'b0, 1'b0, 1'b0);
    applyReset();
    waitPulse(1'b1, 200, n);
    checkOutput("wdt_first_timeout", n, 64);
    waitPulse(1'b1, 200, n);
    checkOutput("wdt_period", n, 64);
    applyReset();
    countPulses(49, ni, nw);
    clrwdt = 1'b1;
    @(negedge clk);
    clrwdt = 1'b0;
    waitPulse(1'b1, 200, n);
    checkOutput("wdt_after_clrwdt", n, 64);
`endif

    applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
    applyReset();
    countPulses(5, ni, nw);
    checkOutput("wr_no_early_pulse", ni, 0);
    tmr0_wr = 1'b1;
    @(negedge clk);
    tmr0_wr = 1'b0;
    waitPulse(1'b0, 50, n);
    checkOutput("tmr0_wr_restart", n, 8);

    applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
    applyReset();
    countPulses(5, ni, nw);
    option_out = 8'h0A;
    @(negedge clk);
    option_out = 8'h02;
    @(negedge clk);
    waitPulse(1'b0, 50, n);
    checkOutput("psa_switch_clears_psc", n, 8);

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyReset();
    for (int ph = 0; ph < 2; ph++) begin
      countPulses(ph + 3, ni, nw);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_drops_tmr0_inc", tmr0_inc, 0);
      checkOutput("rst_drops_wdtmr", wdtmr, 0);
      rst = 1'b0;
    end

    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    applyReset();
    checkOutput("psa1_first_cycle", tmr0_inc, 0);
    countPulses(10 * P, ni, nw);
    checkOutput("psa1_continuous", ni, 10 * P);
    checkOutput("psa1_ps0_wdt_count", nw, WDT_EN ? 10 : 0);

    hold = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) option_out = 8'($urandom_range(0, 255));
      if (hold > 0) hold--;
      else begin
        t0cki = ~t0cki;
        hold = $urandom_range(1, 5);
      end
      tmr0_wr = ($urandom_range(0, 39) == 0);
      clrwdt = ($urandom_range(0, 59) == 0);
      sleep = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    tmr0_wr = 1'b0;
    clrwdt = 1'b0;
    sleep = 1'b0;
    countPulses(4, ni, nw);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
